ntt_stage_seq: RTL and testbench



---
 rtl/ntt_ctrl_pkg.sv | 15 +
 rtl/ntt_seq_watchdog.sv | 36 +++
 rtl/ntt_stage_seq.sv | 149 ++++++++++++++
 tb/tb_ntt_stage_seq.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_ctrl_pkg.sv
// ntt_ctrl_pkg -- shared constants for the NTT stage sequencing controllers.
// Holds the default scalar width, the transform stage count (N=1024 -> 10),
// the default watchdog limit and the 2-bit sequencer state encoding.
package ntt_ctrl_pkg;

    localparam int unsigned STAGE_W     = 32;
    localparam int unsigned LOG2N       = 10;
    localparam int unsigned TIMEOUT_CYC = 4096;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/ntt_seq_watchdog.sv
// ntt_seq_watchdog -- cycle counter that flags a downstream stage that
// never completes. Only instantiated when NTT_STAGE_SEQ_WATCHDOG_EN is defined.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   clr       restart the count (held while a stage is being issued)
//   en        count one cycle (held while waiting for the stage)
//   expired   the count reaches TIMEOUT_CYC at the end of this cycle
module ntt_seq_watchdog #(
    parameter int unsigned TIMEOUT_CYC = ntt_ctrl_pkg::TIMEOUT_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] r_cnt;

    // Cycle counter; the sequencer leaves WAIT on expiry, so it never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Decoded from the register: this WAIT cycle is the TIMEOUT_CYC-th one.
    assign expired = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/ntt_stage_seq.sv
// ntt_stage_seq -- runs a sequence of NTT butterfly stages by handshaking
// with a downstream L-stage controller, one stage at a time.
// Optional build macro: NTT_STAGE_SEQ_WATCHDOG_EN adds a per-stage watchdog
// that aborts the sequence (err=1) if a stage never reports done.
// Ports:
//   ap_clk, ap_rst        clock, asynchronous active-high reset
//   ap_start              level request; first_stage/num_stages sampled with it
//   first_stage           index of the first stage
//   num_stages            stage count, clamped to LOG2N
//   ap_done, ap_ready     one-cycle end-of-sequence pulse
//   ap_idle               high while idle
//   err                   sticky watchdog abort flag (0 without the watchdog)
//   l_stage__ap_start     one-cycle start pulse to the downstream controller
//   l_stage__stage        stage index for the downstream controller
//   l_stage__ap_done      completion pulse from the downstream controller
module ntt_stage_seq #(
    parameter int unsigned STAGE_W     = ntt_ctrl_pkg::STAGE_W,
    parameter int unsigned LOG2N       = ntt_ctrl_pkg::LOG2N,
    parameter int unsigned TIMEOUT_CYC = ntt_ctrl_pkg::TIMEOUT_CYC
) (
    input  logic               ap_clk,
    input  logic               ap_rst,
    input  logic               ap_start,
    input  logic [STAGE_W-1:0] first_stage,
    input  logic [STAGE_W-1:0] num_stages,
    output logic               ap_done,
    output logic               ap_ready,
    output logic               ap_idle,
    output logic               err,
    output logic               l_stage__ap_start,
    output logic [STAGE_W-1:0] l_stage__stage,
    input  logic               l_stage__ap_done
);

    import ntt_ctrl_pkg::*;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [STAGE_W-1:0] r_cur;
    logic [STAGE_W-1:0] w_cur_nxt;
    logic [STAGE_W-1:0] r_rem;
    logic [STAGE_W-1:0] w_rem_nxt;
    logic [STAGE_W-1:0] w_rem_clamp;

`ifdef NTT_STAGE_SEQ_WATCHDOG_EN
    logic r_err;
    logic w_err_nxt;
    logic w_expired;

    ntt_seq_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk     (ap_clk),
        .rst     (ap_rst),
        .clr     (r_state == ST_ISSUE),
        .en      (r_state == ST_WAIT),
        .expired (w_expired)
    );

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err_nxt;
        end
    end

    assign err = r_err;
`else
    // Without the watchdog the limit is irrelevant and WAIT is unbounded.
    logic w_unused_cfg;
    assign w_unused_cfg = ^32'(TIMEOUT_CYC);
    assign err          = 1'b0;
`endif

    // State and stage counters.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_state <= ST_IDLE;
            r_cur   <= '0;
            r_rem   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cur   <= w_cur_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    // Next-state and counter update.
    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur;
        w_rem_nxt   = r_rem;
`ifdef NTT_STAGE_SEQ_WATCHDOG_EN
        w_err_nxt   = r_err;
`endif
        w_rem_clamp = (num_stages > STAGE_W'(LOG2N)) ? STAGE_W'(LOG2N) : num_stages;

        case (r_state)
            ST_IDLE: begin
                if (ap_start) begin
`ifdef NTT_STAGE_SEQ_WATCHDOG_EN
                    w_err_nxt = 1'b0;
`endif
                    if (w_rem_clamp != '0) begin
                        w_cur_nxt   = first_stage;
                        w_rem_nxt   = w_rem_clamp;
                        w_state_nxt = ST_ISSUE;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // A done in the expiry cycle takes priority over the timeout.
                if (l_stage__ap_done) begin
                    if (r_rem == STAGE_W'(1)) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_cur_nxt   = r_cur + STAGE_W'(1);
                        w_rem_nxt   = r_rem - STAGE_W'(1);
                        w_state_nxt = ST_ISSUE;
                    end
                end
`ifdef NTT_STAGE_SEQ_WATCHDOG_EN
                else if (w_expired) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_DONE;
                end
`endif
            end
            default: begin
                // ST_DONE
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs decoded straight from the state register.
    assign ap_idle           = (r_state == ST_IDLE);
    assign ap_done           = (r_state == ST_DONE);
    assign ap_ready          = (r_state == ST_DONE);
    assign l_stage__ap_start = (r_state == ST_ISSUE);
    assign l_stage__stage    = r_cur;

endmodule

// File: tb/tb_ntt_stage_seq.sv
// tb_ntt_stage_seq -- directed bench for ntt_stage_seq. A behavioural
// downstream controller answers each start pulse after a programmable delay.
module tb_ntt_stage_seq;

    logic        clk = 1'b0;
    logic        ap_rst;
    logic        ap_start;
    logic [31:0] first_stage;
    logic [31:0] num_stages;
    logic        ap_done;
    logic        ap_ready;
    logic        ap_idle;
    logic        err;
    logic        l_stage__ap_start;
    logic [31:0] l_stage__stage;
    logic        l_stage__ap_done;

    int          checks   = 0;
    int          failures = 0;

    logic [31:0] stages[$];
    int          resp_delay = 2;
    bit          resp_en    = 1'b1;
    int          resp_cd    = 0;
    int          resp_fired = 0;

    ntt_stage_seq #(
        .STAGE_W     (32),
        .LOG2N       (10),
        .TIMEOUT_CYC (16)
    ) dut (
        .ap_clk            (clk),
        .ap_rst            (ap_rst),
        .ap_start          (ap_start),
        .first_stage       (first_stage),
        .num_stages        (num_stages),
        .ap_done           (ap_done),
        .ap_ready          (ap_ready),
        .ap_idle           (ap_idle),
        .err               (err),
        .l_stage__ap_start (l_stage__ap_start),
        .l_stage__stage    (l_stage__stage),
        .l_stage__ap_done  (l_stage__ap_done)
    );

    always #5 clk = ~clk;

    // Downstream model: records each issued stage, answers resp_delay cycles later.
    initial begin
        l_stage__ap_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            l_stage__ap_done = 1'b0;
            if (l_stage__ap_start) begin
                stages.push_back(l_stage__stage);
                if (resp_en) resp_cd = resp_delay;
            end else if (resp_cd > 0) begin
                resp_cd--;
                if (resp_cd == 0) begin
                    l_stage__ap_done = 1'b1;
                    resp_fired++;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start in the current cycle (cycle 0); return the cycle ap_done is seen
    // and how many cycles ap_idle was low, then step into the following cycle.
    task automatic run_seq(input logic [31:0] f, input logic [31:0] n, input int d,
                           output int done_at, output int idle_low, output logic done_seen_after);
        stages.delete();
        resp_delay  = d;
        resp_en     = 1'b1;
        first_stage = f;
        num_stages  = n;
        ap_start    = 1'b1;
        done_at     = -1;
        idle_low    = 0;
        for (int c = 1; c <= 400; c++) begin
            tick();
            if (c == 1) ap_start = 1'b0;
            if (!ap_idle) idle_low++;
            if (ap_done) begin
                done_at = c;
                break;
            end
        end
        tick();
        done_seen_after = ap_done;
    endtask

    initial begin
        int   done_at;
        int   idle_low;
        logic done_after;
        int   found;
        int   bad;
        int   fired_before;
        int   c_end;

        ap_rst      = 1'b1;
        ap_start    = 1'b0;
        first_stage = '0;
        num_stages  = '0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state.
        check("rst_idle",      32'(ap_idle), 32'd1);
        check("rst_done",      32'(ap_done), 32'd0);
        check("rst_ready",     32'(ap_ready), 32'd0);
        check("rst_lstart",    32'(l_stage__ap_start), 32'd0);
        check("rst_stage",     l_stage__stage, 32'd0);
        check("rst_err",       32'(err), 32'd0);
        ap_rst = 1'b0;
        tick();

        // Full 10-stage run, downstream latency 2: done at 10*3+1.
        run_seq(32'd0, 32'd10, 2, done_at, idle_low, done_after);
        check("full_done_cycle", 32'(done_at), 32'd31);
        check("full_pulses",     32'(stages.size()), 32'd10);
        for (int i = 0; i < stages.size(); i++) check($sformatf("full_stage%0d", i), stages[i], 32'(i));
        check("full_err",        32'(err), 32'd0);
        check("full_done_once",  32'(done_after), 32'd0);
        check("full_idle_after", 32'(ap_idle), 32'd1);

        // Zero stages: straight to DONE.
        run_seq(32'd4, 32'd0, 2, done_at, idle_low, done_after);
        check("zero_done_cycle", 32'(done_at), 32'd1);
        check("zero_pulses",     32'(stages.size()), 32'd0);
        check("zero_idle_low",   32'(idle_low), 32'd1);
        check("zero_done_once",  32'(done_after), 32'd0);

        // Count above LOG2N is clamped to 10.
        run_seq(32'd5, 32'd15, 2, done_at, idle_low, done_after);
        check("clamp_pulses",     32'(stages.size()), 32'd10);
        check("clamp_done_cycle", 32'(done_at), 32'd31);
        if (stages.size() == 10) check("clamp_last_stage", stages[9], 32'd14);

        // Stage index wraps from all-ones to zero; latency 1 exercised elsewhere.
        run_seq(32'hFFFF_FFFF, 32'd2, 2, done_at, idle_low, done_after);
        check("wrap_pulses",     32'(stages.size()), 32'd2);
        if (stages.size() == 2) begin
            check("wrap_stage0", stages[0], 32'hFFFF_FFFF);
            check("wrap_stage1", stages[1], 32'h0000_0000);
        end
        check("wrap_done_cycle", 32'(done_at), 32'd7);

        // Three stages, latency 1: done at 3*2+1.
        run_seq(32'd2, 32'd3, 1, done_at, idle_low, done_after);
        check("lat1_done_cycle", 32'(done_at), 32'd7);
        check("lat1_pulses",     32'(stages.size()), 32'd3);

        // ap_start held through DONE restarts in the following IDLE cycle.
        stages.delete();
        resp_delay  = 2;
        first_stage = 32'd7;
        num_stages  = 32'd1;
        ap_start    = 1'b1;
        done_at     = -1;
        for (int c = 1; c <= 100; c++) begin
            tick();
            if (ap_done) begin
                done_at = c;
                break;
            end
        end
        check("b2b_done_cycle", 32'(done_at), 32'd4);
        tick();
        check("b2b_idle_gap",   32'(ap_idle), 32'd1);
        tick();
        ap_start = 1'b0;
        check("b2b_restart",    32'(l_stage__ap_start), 32'd1);
        check("b2b_stage",      l_stage__stage, 32'd7);
        c_end = -1;
        for (int c = 1; c <= 100; c++) begin
            tick();
            if (ap_done) begin
                c_end = c;
                break;
            end
        end
        check("b2b_second_done", 32'(c_end), 32'd3);
        tick();
        check("b2b_pulses",      32'(stages.size()), 32'd2);

        // Reset during WAIT of stage 3; the late downstream done is ignored.
        stages.delete();
        resp_delay  = 4;
        first_stage = 32'd0;
        num_stages  = 32'd10;
        ap_start    = 1'b1;
        found       = 0;
        for (int c = 1; c <= 200; c++) begin
            tick();
            if (c == 1) ap_start = 1'b0;
            if (l_stage__ap_start && l_stage__stage == 32'd3) begin
                found = 1;
                break;
            end
        end
        check("rst_mid_reached", 32'(found), 32'd1);
        tick();
        fired_before = resp_fired;
        ap_rst = 1'b1;
        #1;
        check("rst_mid_idle",   32'(ap_idle), 32'd1);
        check("rst_mid_stage",  l_stage__stage, 32'd0);
        check("rst_mid_lstart", 32'(l_stage__ap_start), 32'd0);
        check("rst_mid_done",   32'(ap_done), 32'd0);
        check("rst_mid_ready",  32'(ap_ready), 32'd0);
        tick();
        ap_rst = 1'b0;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (!ap_idle || ap_done || l_stage__ap_start) bad++;
        end
        check("rst_late_fired",   32'(resp_fired - fired_before), 32'd1);
        check("rst_late_ignored", 32'(bad), 32'd0);
        run_seq(32'd0, 32'd1, 4, done_at, idle_low, done_after);
        check("rst_fresh_done",   32'(done_at), 32'd6);
        check("rst_fresh_pulses", 32'(stages.size()), 32'd1);

`ifdef NTT_STAGE_SEQ_WATCHDOG_EN
        // Silent downstream: abort 17 cycles after ISSUE (cycle 1) with err set.
        stages.delete();
        resp_en     = 1'b0;
        first_stage = 32'd0;
        num_stages  = 32'd1;
        ap_start    = 1'b1;
        done_at     = -1;
        for (int c = 1; c <= 100; c++) begin
            tick();
            if (c == 1) ap_start = 1'b0;
            if (ap_done) begin
                done_at = c;
                break;
            end
        end
        check("wd_done_cycle", 32'(done_at), 32'd18);
        check("wd_err",        32'(err), 32'd1);
        tick();
        check("wd_done_once",  32'(ap_done), 32'd0);
        check("wd_err_sticky", 32'(err), 32'd1);
        resp_en    = 1'b1;
        resp_delay = 2;
        ap_start   = 1'b1;
        tick();
        ap_start = 1'b0;
        check("wd_err_cleared", 32'(err), 32'd0);
        for (int c = 0; c < 10; c++) tick();
        check("wd_recover_idle", 32'(ap_idle), 32'd1);
`else
        // Silent downstream: WAIT holds indefinitely and err stays low.
        stages.delete();
        resp_en     = 1'b0;
        first_stage = 32'd9;
        num_stages  = 32'd1;
        ap_start    = 1'b1;
        bad         = 0;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (c == 1) ap_start = 1'b0;
            if (ap_done || err) bad++;
        end
        check("nowd_no_done", 32'(bad), 32'd0);
        check("nowd_waiting", 32'(ap_idle), 32'd0);
        check("nowd_stage",   l_stage__stage, 32'd9);
        ap_rst = 1'b1;
        tick();
        ap_rst  = 1'b0;
        resp_en = 1'b1;
        tick();
        check("nowd_recover_idle", 32'(ap_idle), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
